// File: rtl/sub_pkg.sv
// Shared types and constants for the bit-serial subtractor.
package sub_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } sub_state_t;

  // Two's-complement subtract: a + ~b + 1, so the carry chain starts at 1.
  localparam logic SUB_CIN_INIT = 1'b1;

endpackage

// File: rtl/serial_subtractor_if.sv
// Operand/result handshake bundle for the bit-serial subtractor.
interface serial_subtractor_if #(
  parameter int unsigned WIDTH = 8
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] diff;
  logic             borrow;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, diff, borrow
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, diff, borrow
  );

endinterface

// File: rtl/serial_subtractor_fa.sv
// 1-bit full-adder cell.
module serial_subtractor_fa (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = a - b, one bit per clock, LSB first.
module serial_subtractor
  import sub_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input logic               clk,
  input logic               rst,
  serial_subtractor_if.slave bus
);

  localparam int unsigned CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  sub_state_t       state_q, state_d;
  logic [WIDTH-1:0] sa_q, sa_d;
  logic [WIDTH-1:0] sb_q, sb_d;
  logic [WIDTH-1:0] sd_q, sd_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             borrow_q, borrow_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    count_q, count_d;
  logic             sum;
  logic             cout;

  serial_subtractor_fa u_fa (
    .a    (sa_q[0]),
    .b    (~sb_q[0]),
    .cin  (carry_q),
    .sum  (sum),
    .cout (cout)
  );

  // Next-state: capture operands, shift one bit per RUN cycle, publish result on entry to DONE.
  always_comb begin
    state_d  = state_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    sd_d     = sd_q;
    carry_d  = carry_q;
    count_d  = count_q;
    diff_d   = diff_q;
    borrow_d = borrow_q;
    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          sa_d    = bus.a;
          sb_d    = bus.b;
          carry_d = SUB_CIN_INIT;
          count_d = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        sa_d    = sa_q >> 1;
        sb_d    = sb_q >> 1;
        sd_d    = (sd_q >> 1) | (WIDTH'(sum) << (WIDTH - 1));
        carry_d = cout;
        count_d = count_q + 1'b1;
        if (count_q == LAST) begin
          state_d  = DONE;
          diff_d   = sd_d;
          // Carry-out of a + ~b + 1 is 1 exactly when no borrow occurred.
          borrow_d = ~cout;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register with synchronous active-high reset; reset aborts any operation.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      sa_q     <= '0;
      sb_q     <= '0;
      sd_q     <= '0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
      carry_q  <= 1'b0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      sd_q     <= sd_d;
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
      carry_q  <= carry_d;
      count_q  <= count_d;
    end
  end

  // Handshake flags are masked during the reset cycle itself.
  assign bus.in_ready  = (state_q == IDLE) && !rst;
  assign bus.out_valid = (state_q == DONE) && !rst;
  assign bus.diff      = diff_q;
  assign bus.borrow    = borrow_q;

endmodule
